// File: rtl/fmps_stream_packer.sv
// rtl/fmps_stream_packer.sv - packs FA-framed FMPS samples into header+data AXI-stream frames
module fmps_stream_packer #(
  parameter int INDEX_WIDTH = 5,
  parameter int FIFO_AW     = 6
) (
  input  logic                   sysClk,
  input  logic                   sysReset,
  input  logic                   FAstrobe,
  input  logic                   fmpsValid,
  input  logic [INDEX_WIDTH-1:0] fmpsIndex,
  input  logic [31:0]            fmpsData,
  output logic                   M_TVALID,
  input  logic                   M_TREADY,
  output logic [31:0]            M_TDATA,
  output logic [INDEX_WIDTH-1:0] M_TUSER,
  output logic                   M_TLAST,
  output logic [15:0]            dropCount,
  output logic [15:0]            frameCount
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;

  typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

  state_t state, state_nxt;

  // sample FIFO storage and bookkeeping
  logic [INDEX_WIDTH+31:0] mem [DEPTH];
  logic [FIFO_AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]           fifo_cnt;

  // samples gathered since the last frame boundary
  logic [CW-1:0] col_cnt;
  logic          col_merged, col_dropped;

  // one-deep pending frame descriptor waiting for the output FSM
  logic          slot_valid;
  logic [CW-1:0] slot_cnt;
  logic          slot_merged, slot_dropped;

  // frame currently being emitted
  logic [CW-1:0] hdr_cnt;
  logic          hdr_merged, hdr_dropped;
  logic [CW-1:0] rem;
  logic [15:0]   seq;
  logic [9:0]    cnt_field;

  logic full, push, drop, accept, pop, consume;

  assign full      = (fifo_cnt == CW'(DEPTH));
  assign push      = fmpsValid & ~full;
  assign drop      = fmpsValid & full;
  assign accept    = M_TVALID & M_TREADY;
  assign pop       = (state == DATA) & accept;
  assign consume   = (state == IDLE) & slot_valid;
  assign cnt_field = 10'(hdr_cnt);

  // FIFO write storage; contents need no reset since pointers define validity
  always_ff @(posedge sysClk) begin
    if (!sysReset && push) mem[wr_ptr] <= {fmpsIndex, fmpsData};
  end

  // FIFO pointers and occupancy; a same-cycle push and pop leave the count unchanged
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

  // collect state, pending slot and drop counter; a strobe-coincident sample opens the next frame
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      col_cnt      <= '0;
      col_merged   <= 1'b0;
      col_dropped  <= 1'b0;
      slot_valid   <= 1'b0;
      slot_cnt     <= '0;
      slot_merged  <= 1'b0;
      slot_dropped <= 1'b0;
      dropCount    <= '0;
    end else begin
      if (drop && dropCount != 16'hFFFF) dropCount <= dropCount + 16'd1;
      if (FAstrobe && (!slot_valid || consume)) begin
        slot_valid   <= 1'b1;
        slot_cnt     <= col_cnt;
        slot_merged  <= col_merged;
        slot_dropped <= col_dropped;
        col_cnt      <= CW'(push);
        col_merged   <= 1'b0;
        col_dropped  <= drop;
      end else begin
        // slot still busy on a strobe: keep collecting so the next frame spans both periods
        if (consume)  slot_valid <= 1'b0;
        if (FAstrobe) col_merged <= 1'b1;
        col_cnt     <= col_cnt + CW'(push);
        col_dropped <= col_dropped | drop;
      end
    end
  end

  // output FSM state, header capture, sequence and frame counters
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      state       <= IDLE;
      hdr_cnt     <= '0;
      hdr_merged  <= 1'b0;
      hdr_dropped <= 1'b0;
      rem         <= '0;
      seq         <= '0;
      frameCount  <= '0;
    end else begin
      state <= state_nxt;
      if (consume) begin
        hdr_cnt     <= slot_cnt;
        hdr_merged  <= slot_merged;
        hdr_dropped <= slot_dropped;
      end
      if (state == HEADER && accept) begin
        seq <= seq + 16'd1;
        rem <= hdr_cnt;
        if (hdr_cnt == '0) frameCount <= frameCount + 16'd1;
      end
      if (pop) begin
        rem <= rem - 1'b1;
        if (rem == CW'(1)) frameCount <= frameCount + 16'd1;
      end
    end
  end

  // next-state and stream outputs; outputs derive from held state so they are stable under stall
  always_comb begin
    state_nxt = state;
    M_TVALID  = 1'b0;
    M_TDATA   = '0;
    M_TUSER   = '0;
    M_TLAST   = 1'b0;
    case (state)
      IDLE: begin
        if (slot_valid) state_nxt = HEADER;
      end
      HEADER: begin
        M_TVALID = 1'b1;
        M_TDATA  = {4'hF, hdr_merged, hdr_dropped, cnt_field, seq};
        M_TLAST  = (hdr_cnt == '0);
        if (accept) state_nxt = (hdr_cnt == '0) ? IDLE : DATA;
      end
      DATA: begin
        M_TVALID           = 1'b1;
        {M_TUSER, M_TDATA} = mem[rd_ptr];
        M_TLAST            = (rem == CW'(1));
        if (accept && rem == CW'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fmps_stream_packer.sv
// tb/tb_fmps_stream_packer.sv - directed self-checking bench for fmps_stream_packer
module tb_fmps_stream_packer;

  logic        sysClk = 1'b0;
  logic        sysReset = 1'b1;
  logic        FAstrobe = 1'b0;
  logic        fmpsValid = 1'b0;
  logic [4:0]  fmpsIndex = '0;
  logic [31:0] fmpsData = '0;
  logic        M_TVALID;
  logic        M_TREADY = 1'b0;
  logic [31:0] M_TDATA;
  logic [4:0]  M_TUSER;
  logic        M_TLAST;
  logic [15:0] dropCount;
  logic [15:0] frameCount;

  int checks = 0;
  int failures = 0;

  fmps_stream_packer #(.INDEX_WIDTH(5), .FIFO_AW(2)) dut (
    .sysClk(sysClk), .sysReset(sysReset), .FAstrobe(FAstrobe),
    .fmpsValid(fmpsValid), .fmpsIndex(fmpsIndex), .fmpsData(fmpsData),
    .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .M_TDATA(M_TDATA),
    .M_TUSER(M_TUSER), .M_TLAST(M_TLAST),
    .dropCount(dropCount), .frameCount(frameCount)
  );

  always #5 sysClk = ~sysClk;

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sample(input logic [4:0] idx, input logic [31:0] d, input logic stb);
    fmpsValid = 1'b1;
    fmpsIndex = idx;
    fmpsData  = d;
    FAstrobe  = stb;
    tick();
    fmpsValid = 1'b0;
    FAstrobe  = 1'b0;
  endtask

  task automatic strobe();
    FAstrobe = 1'b1;
    tick();
    FAstrobe = 1'b0;
  endtask

  task automatic do_reset();
    sysReset = 1'b1;
    tick();
    tick();
    sysReset = 1'b0;
  endtask

  // waits for the next word, checks it on every valid cycle (stalled or not) until it is accepted
  task automatic expect_word(input string tag, input logic [31:0] d, input logic [4:0] u,
                             input logic l, input bit stall);
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (stall && i < 20) M_TREADY = 1'($urandom_range(0, 1));
      else M_TREADY = 1'b1;
      if (M_TVALID === 1'b1) begin
        chk({tag, "/data"}, M_TDATA, d);
        chk({tag, "/user"}, 32'(M_TUSER), 32'(u));
        chk({tag, "/last"}, 32'(M_TLAST), 32'(l));
        if (M_TREADY) done = 1'b1;
      end
      tick();
    end
    if (!done) begin
      checks++;
      failures++;
      $error("FAIL %s: observed=no word expected=%h", tag, d);
    end
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_valid", 32'(M_TVALID), 32'd0);
    chk("rst_data", M_TDATA, 32'd0);
    chk("rst_user", 32'(M_TUSER), 32'd0);
    chk("rst_last", 32'(M_TLAST), 32'd0);
    chk("rst_drop", 32'(dropCount), 32'd0);
    chk("rst_frames", 32'(frameCount), 32'd0);

    // basic frame with header latency
    M_TREADY = 1'b1;
    sample(5'd1, 32'h11, 1'b0);
    sample(5'd4, 32'h44, 1'b0);
    sample(5'd7, 32'h77, 1'b0);
    strobe();
    chk("lat_slot", 32'(M_TVALID), 32'd0);
    tick();
    chk("lat_hdr", 32'(M_TVALID), 32'd1);
    expect_word("a_hdr", 32'hF0030000, 5'd0, 1'b0, 1'b0);
    expect_word("a_w0", 32'h11, 5'd1, 1'b0, 1'b0);
    expect_word("a_w1", 32'h44, 5'd4, 1'b0, 1'b0);
    expect_word("a_w2", 32'h77, 5'd7, 1'b1, 1'b0);
    chk("a_frames", 32'(frameCount), 32'd1);

    // empty frames carry TLAST on the header
    do_reset();
    strobe();
    expect_word("b_hdr0", 32'hF0000000, 5'd0, 1'b1, 1'b0);
    strobe();
    expect_word("b_hdr1", 32'hF0000001, 5'd0, 1'b1, 1'b0);
    chk("b_frames", 32'(frameCount), 32'd2);

    // FIFO overflow (depth 4)
    do_reset();
    for (int i = 0; i < 6; i++) sample(5'(i + 1), 32'h100 + 32'(i), 1'b0);
    strobe();
    chk("c_drop", 32'(dropCount), 32'd2);
    expect_word("c_hdr", 32'hF4040000, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      expect_word("c_w", 32'h100 + 32'(i), 5'(i + 1), (i == 3), 1'b0);

    // backpressure: slot occupied during later strobes merges periods
    do_reset();
    M_TREADY = 1'b0;
    sample(5'd2, 32'hA0, 1'b0);
    strobe();
    tick();
    chk("d_stall_v", 32'(M_TVALID), 32'd1);
    chk("d_stall_d0", M_TDATA, 32'hF0010000);
    sample(5'd3, 32'hB0, 1'b0);
    sample(5'd5, 32'hB1, 1'b0);
    strobe();
    sample(5'd6, 32'hC0, 1'b0);
    strobe();
    tick();
    strobe();
    tick();
    chk("d_stall_d1", M_TDATA, 32'hF0010000);
    chk("d_drop", 32'(dropCount), 32'd0);
    expect_word("d_f0h", 32'hF0010000, 5'd0, 1'b0, 1'b0);
    expect_word("d_f0w", 32'hA0, 5'd2, 1'b1, 1'b0);
    expect_word("d_f1h", 32'hF0020001, 5'd0, 1'b0, 1'b0);
    expect_word("d_f1w0", 32'hB0, 5'd3, 1'b0, 1'b0);
    expect_word("d_f1w1", 32'hB1, 5'd5, 1'b1, 1'b0);
    strobe();
    expect_word("d_f2h", 32'hF8010002, 5'd0, 1'b0, 1'b0);
    expect_word("d_f2w", 32'hC0, 5'd6, 1'b1, 1'b0);
    chk("d_frames", 32'(frameCount), 32'd3);

    // sample coincident with the strobe belongs to the next frame
    do_reset();
    sample(5'd1, 32'h51, 1'b0);
    sample(5'd2, 32'h52, 1'b1);
    expect_word("e_f0h", 32'hF0010000, 5'd0, 1'b0, 1'b0);
    expect_word("e_f0w", 32'h51, 5'd1, 1'b1, 1'b0);
    strobe();
    expect_word("e_f1h", 32'hF0010001, 5'd0, 1'b0, 1'b0);
    expect_word("e_f1w", 32'h52, 5'd2, 1'b1, 1'b0);

    // random ready: order and values unchanged, stable while stalled
    do_reset();
    sample(5'd3, 32'h300, 1'b0);
    sample(5'd9, 32'h309, 1'b0);
    sample(5'd12, 32'h30C, 1'b0);
    strobe();
    expect_word("f_hdr", 32'hF0030000, 5'd0, 1'b0, 1'b1);
    expect_word("f_w0", 32'h300, 5'd3, 1'b0, 1'b1);
    expect_word("f_w1", 32'h309, 5'd9, 1'b0, 1'b1);
    expect_word("f_w2", 32'h30C, 5'd12, 1'b1, 1'b1);

    // reset in DATA abandons the frame; inputs ignored during reset
    do_reset();
    sample(5'd1, 32'hD1, 1'b0);
    sample(5'd2, 32'hD2, 1'b0);
    strobe();
    expect_word("g_hdr", 32'hF0020000, 5'd0, 1'b0, 1'b0);
    M_TREADY = 1'b0;
    chk("g_data_v", 32'(M_TVALID), 32'd1);
    chk("g_data_d", M_TDATA, 32'hD1);
    sysReset  = 1'b1;
    fmpsValid = 1'b1;
    fmpsIndex = 5'd9;
    fmpsData  = 32'hDEAD;
    FAstrobe  = 1'b1;
    tick();
    chk("g_rst_v", 32'(M_TVALID), 32'd0);
    chk("g_rst_d", M_TDATA, 32'd0);
    chk("g_rst_frames", 32'(frameCount), 32'd0);
    tick();
    sysReset  = 1'b0;
    fmpsValid = 1'b0;
    FAstrobe  = 1'b0;
    tick();
    tick();
    chk("g_post_v", 32'(M_TVALID), 32'd0);
    strobe();
    expect_word("g_hdr0", 32'hF0000000, 5'd0, 1'b1, 1'b0);
    sample(5'd3, 32'h33, 1'b0);
    strobe();
    expect_word("g_hdr1", 32'hF0010001, 5'd0, 1'b0, 1'b0);
    expect_word("g_w", 32'h33, 5'd3, 1'b1, 1'b0);
    chk("g_frames", 32'(frameCount), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
